// File: rtl/e203_tcm_sram_pmu_if.sv
// Request/response bus between the core's TCM controller (master) and the
// banked TCM SRAM (slave).
interface e203_tcm_sram_pmu_if #(
    parameter int DW    = 32,
    parameter int AW    = 14,
    parameter int BANKS = 2
);
    localparam int MW = DW / 8;

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [MW-1:0]    req_wem;
    logic [DW-1:0]    req_din;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_dout;
    logic [BANKS-1:0] bank_cs;

    modport master (
        output req_valid, req_we, req_addr, req_wem, req_din,
        input  req_ready, rsp_valid, rsp_dout, bank_cs
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wem, req_din,
        output req_ready, rsp_valid, rsp_dout, bank_cs
    );
endinterface

// File: rtl/e203_tcm_sram_pmu.sv
// Banked TCM SRAM with a request-level power manager.
// Requests are only accepted in ACT; LS/DS/SD are left through a counted
// WAKE state. Reads already accepted drain through the data path whatever
// the power state does next.
module e203_tcm_sram_pmu #(
    parameter int DW       = 32,
    parameter int AW       = 14,
    parameter int MW       = DW / 8,
    parameter int BANKS    = 2,
    parameter int DOUT_REG = 0,
    parameter int IDLE_LS  = 8,
    parameter int WAKE_LS  = 1,
    parameter int WAKE_DS  = 4,
    parameter int WAKE_SD  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    e203_tcm_sram_pmu_if.slave        bus,
    input  logic                      pwr_ds_req,
    input  logic                      pwr_sd_req,
    output logic [2:0]                pwr_state
);
    // Bank select uses the top address bits; the rest index inside a bank.
    localparam int BSW     = (BANKS > 1) ? $clog2(BANKS) : 0;
    localparam int BIW     = (BANKS > 1) ? BSW : 1;
    localparam int WIW     = AW - BSW;
    localparam int DEPTH_B = 2 ** WIW;
    localparam int CNT_MAX = (IDLE_LS > WAKE_SD) ? IDLE_LS : WAKE_SD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] IDLE_LIM  = CW'(IDLE_LS);
    localparam logic [CW-1:0] WAKE_LS_C = CW'(WAKE_LS);
    localparam logic [CW-1:0] WAKE_DS_C = CW'(WAKE_DS);
    localparam logic [CW-1:0] WAKE_SD_C = CW'(WAKE_SD);
    localparam bit            AUTO_LS   = (IDLE_LS != 0);

    typedef enum logic [2:0] {
        ST_ACT  = 3'd0,
        ST_LS   = 3'd1,
        ST_DS   = 3'd2,
        ST_SD   = 3'd3,
        ST_WAKE = 3'd4
    } pwr_st_e;

    pwr_st_e          state_r;
    pwr_st_e          state_nxt_s;
    logic [CW-1:0]    idle_cnt_r;
    logic [CW-1:0]    idle_cnt_nxt_s;
    logic [CW-1:0]    idle_step_s;
    logic [CW-1:0]    wake_cnt_r;
    logic [CW-1:0]    wake_cnt_nxt_s;

    logic             req_ready_s;
    logic             accept_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             rd_inflight_s;
    logic [BIW-1:0]   bank_idx_s;
    logic [WIW-1:0]   word_idx_s;
    logic [BANKS-1:0] bank_cs_s;

    logic [DW-1:0]    mem_r [BANKS][DEPTH_B];
    logic             rd_vld1_r;
    logic [DW-1:0]    rd_data1_r;
    logic             rsp_valid_s;
    logic [DW-1:0]    rsp_dout_s;

    generate
        if (BANKS > 1) begin : g_bank_sel
            assign bank_idx_s = bus.req_addr[AW-1 -: BSW];
        end else begin : g_bank_single
            assign bank_idx_s = 1'b0;
        end
    endgenerate

    assign word_idx_s = bus.req_addr[WIW-1:0];

    // Idle count for the current ACT cycle: clears on a request, saturates at the limit.
    always_comb begin
        if (bus.req_valid) begin
            idle_step_s = '0;
        end else if (idle_cnt_r >= IDLE_LIM) begin
            idle_step_s = idle_cnt_r;
        end else begin
            idle_step_s = idle_cnt_r + CNT_ONE;
        end
    end

    // Power FSM state register with its idle and wake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_ACT;
            idle_cnt_r <= '0;
            wake_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            idle_cnt_r <= idle_cnt_nxt_s;
            wake_cnt_r <= wake_cnt_nxt_s;
        end
    end

    // Power FSM next state; the idle count only survives while staying in ACT.
    always_comb begin
        state_nxt_s    = state_r;
        idle_cnt_nxt_s = '0;
        wake_cnt_nxt_s = wake_cnt_r;
        case (state_r)
            ST_ACT: begin
                if (pwr_sd_req) begin
                    state_nxt_s = ST_SD;
                end else if (pwr_ds_req) begin
                    state_nxt_s = ST_DS;
                end else if (AUTO_LS && (idle_step_s == IDLE_LIM) && !rd_inflight_s) begin
                    state_nxt_s = ST_LS;
                end else begin
                    state_nxt_s    = ST_ACT;
                    idle_cnt_nxt_s = idle_step_s;
                end
            end
            ST_LS: begin
                if (pwr_sd_req) begin
                    state_nxt_s = ST_SD;
                end else if (pwr_ds_req) begin
                    state_nxt_s = ST_DS;
                end else if (bus.req_valid) begin
                    state_nxt_s    = ST_WAKE;
                    wake_cnt_nxt_s = WAKE_LS_C;
                end else begin
                    state_nxt_s = ST_LS;
                end
            end
            ST_DS: begin
                if (pwr_sd_req) begin
                    state_nxt_s = ST_SD;
                end else if (!pwr_ds_req) begin
                    state_nxt_s    = ST_WAKE;
                    wake_cnt_nxt_s = WAKE_DS_C;
                end else begin
                    state_nxt_s = ST_DS;
                end
            end
            ST_SD: begin
                if (pwr_sd_req) begin
                    state_nxt_s = ST_SD;
                end else if (pwr_ds_req) begin
                    state_nxt_s = ST_DS;
                end else begin
                    state_nxt_s    = ST_WAKE;
                    wake_cnt_nxt_s = WAKE_SD_C;
                end
            end
            ST_WAKE: begin
                if (pwr_sd_req) begin
                    state_nxt_s = ST_SD;
                end else if (pwr_ds_req) begin
                    state_nxt_s = ST_DS;
                end else if (wake_cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_ACT;
                end else begin
                    state_nxt_s    = ST_WAKE;
                    wake_cnt_nxt_s = wake_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s    = ST_ACT;
                wake_cnt_nxt_s = '0;
            end
        endcase
    end

    // Power FSM outputs: ready from state, accept qualification, one-hot bank select.
    always_comb begin
        req_ready_s = (state_r == ST_ACT);
        accept_s    = bus.req_valid && req_ready_s;
        rd_acc_s    = accept_s && !bus.req_we;
        wr_acc_s    = accept_s && bus.req_we;
        bank_cs_s   = '0;
        if (accept_s) begin
            bank_cs_s[bank_idx_s] = 1'b1;
        end else begin
            bank_cs_s = '0;
        end
    end

    // Array write port: byte-masked update of the addressed word; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int b = 0; b < MW; b++) begin
                if (bus.req_wem[b]) begin
                    mem_r[bank_idx_s][word_idx_s][b*8 +: 8] <= bus.req_din[b*8 +: 8];
                end
            end
        end
    end

    // First read stage: array lookup captured at the accept edge, held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld1_r  <= 1'b0;
            rd_data1_r <= '0;
        end else begin
            rd_vld1_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data1_r <= mem_r[bank_idx_s][word_idx_s];
            end
        end
    end

    generate
        if (DOUT_REG != 0) begin : g_dout_reg
            logic          rd_vld2_r;
            logic [DW-1:0] rd_data2_r;

            // Optional output stage: adds one cycle of read latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_vld2_r  <= 1'b0;
                    rd_data2_r <= '0;
                end else begin
                    rd_vld2_r <= rd_vld1_r;
                    if (rd_vld1_r) begin
                        rd_data2_r <= rd_data1_r;
                    end
                end
            end

            assign rsp_valid_s   = rd_vld2_r;
            assign rsp_dout_s    = rd_data2_r;
            assign rd_inflight_s = rd_acc_s | rd_vld1_r;
        end else begin : g_dout_direct
            assign rsp_valid_s   = rd_vld1_r;
            assign rsp_dout_s    = rd_data1_r;
            assign rd_inflight_s = rd_acc_s;
        end
    endgenerate

    assign bus.req_ready = req_ready_s;
    assign bus.bank_cs   = bank_cs_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_dout  = rsp_dout_s;
    assign pwr_state     = state_r;
endmodule

// File: tb/tb_e203_tcm_sram_pmu.sv
// Bench for e203_tcm_sram_pmu: two instances (direct and registered read
// output) share one stimulus stream and are compared each cycle against a
// cycle-level reference model of the power rules and a word-level memory map.
module tb_e203_tcm_sram_pmu;
    localparam int DW = 32, AW = 14, BANKS = 2;
    localparam int IDLE = 8, WLS = 1, WDS = 4, WSD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ds, sd;
    logic          v, we;
    logic [AW-1:0] addr;
    logic [3:0]    wem;
    logic [31:0]   din;
    logic [2:0]    pwr_state0, pwr_state1;

    e203_tcm_sram_pmu_if #(.DW(DW), .AW(AW), .BANKS(BANKS)) bus0 ();
    e203_tcm_sram_pmu_if #(.DW(DW), .AW(AW), .BANKS(BANKS)) bus1 ();

    assign bus0.req_valid = v;    assign bus1.req_valid = v;
    assign bus0.req_we    = we;   assign bus1.req_we    = we;
    assign bus0.req_addr  = addr; assign bus1.req_addr  = addr;
    assign bus0.req_wem   = wem;  assign bus1.req_wem   = wem;
    assign bus0.req_din   = din;  assign bus1.req_din   = din;

    e203_tcm_sram_pmu #(.DW(DW), .AW(AW), .BANKS(BANKS), .DOUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .pwr_ds_req(ds), .pwr_sd_req(sd), .pwr_state(pwr_state0)
    );

    e203_tcm_sram_pmu #(.DW(DW), .AW(AW), .BANKS(BANKS), .DOUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .pwr_ds_req(ds), .pwr_sd_req(sd), .pwr_state(pwr_state1)
    );

    // ---------------- reference model ----------------
    typedef struct { int due; bit [31:0] data; } rsp_t;
    rsp_t       q0[$], q1[$];
    bit [31:0]  m_mem [int];
    int         m_state, m_idle, m_wake_left;
    bit [31:0]  last0, last1;
    int         cyc, n_chk, n_pass;
    bit         chk_en, dut_acc;
    logic [AW-1:0] pool [8] = '{14'h0010, 14'h0011, 14'h2000, 14'h2001,
                                14'h1FFF, 14'h3FFF, 14'h0000, 14'h0123};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Apply one clock of spec rules to the model using the current inputs.
    task automatic model_step(input bit rdy);
        int nxt;
        bit [31:0] w;
        if (rst) begin
            m_state = 0; m_idle = 0; m_wake_left = 0;
            q0.delete(); q1.delete(); last0 = '0; last1 = '0;
            return;
        end
        if (v && rdy) begin
            if (we) begin
                if (m_mem.exists(int'(addr)) || wem == 4'hF) begin
                    w = m_mem.exists(int'(addr)) ? m_mem[int'(addr)] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (wem[b]) w[b*8 +: 8] = din[b*8 +: 8];
                    m_mem[int'(addr)] = w;
                end
            end else begin
                q0.push_back('{cyc + 1, m_mem[int'(addr)]});
                q1.push_back('{cyc + 2, m_mem[int'(addr)]});
            end
        end
        nxt = m_state;
        case (m_state)
            0: if (sd) nxt = 3; else if (ds) nxt = 2;
               else begin
                   // reads are never in flight after IDLE request-free cycles
                   m_idle = v ? 0 : ((m_idle < IDLE) ? m_idle + 1 : m_idle);
                   if (m_idle == IDLE) nxt = 1;
               end
            1: if (sd) nxt = 3; else if (ds) nxt = 2;
               else if (v) begin nxt = 4; m_wake_left = WLS; end
            2: if (sd) nxt = 3; else if (!ds) begin nxt = 4; m_wake_left = WDS; end
            3: if (!sd) begin
                   if (ds) nxt = 2; else begin nxt = 4; m_wake_left = WSD; end
               end
            default: if (sd) nxt = 3; else if (ds) nxt = 2;
               else if (m_wake_left == 1) nxt = 0;
               else m_wake_left = m_wake_left - 1;
        endcase
        if (nxt != 0) m_idle = 0;
        if (nxt == 3 && m_state != 3) m_mem.delete();
        m_state = nxt;
    endtask

    // One clock: compare outputs mid-cycle, advance model, step past the edge.
    task automatic tick();
        bit rdy, ev0, ev1;
        logic [63:0] bexp;
        @(negedge clk);
        rdy = (m_state == 0);
        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        if (ev0) begin last0 = q0[0].data; void'(q0.pop_front()); end
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev1) begin last1 = q1[0].data; void'(q1.pop_front()); end
        bexp = (v && rdy) ? (64'd1 << addr[AW-1]) : 64'd0;
        dut_acc = v && bus0.req_ready && !rst;
        if (chk_en) begin
            check("pwr_state0", pwr_state0, m_state);
            check("pwr_state1", pwr_state1, m_state);
            check("req_ready", bus0.req_ready, rdy);
            check("bank_cs0", bus0.bank_cs, bexp);
            check("bank_cs1", bus1.bank_cs, bexp);
            check("rsp_valid0", bus0.rsp_valid, ev0);
            check("rsp_dout0", bus0.rsp_dout, last0);
            check("rsp_valid1", bus1.rsp_valid, ev1);
            check("rsp_dout1", bus1.rsp_dout, last1);
        end
        model_step(rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold a request until the DUT accepts it, bounded.
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [3:0] m,
                          input logic [31:0] d);
        int guard;
        guard = 0;
        v = 1'b1; we = w; addr = a; wem = m; din = d;
        dut_acc = 1'b0;
        while (!dut_acc && guard < 64) begin
            tick();
            guard++;
        end
        check("accept_seen", dut_acc, 1'b1);
        v = 1'b0;
    endtask

    task automatic idle(input int n);
        v = 1'b0;
        repeat (n) tick();
    endtask

    int idle_run;
    int r;
    logic [AW-1:0] ra;

    initial begin
        rst = 1'b1; ds = 1'b0; sd = 1'b0; v = 1'b0; we = 1'b0;
        addr = '0; wem = '0; din = '0;
        cyc = 0; n_chk = 0; n_pass = 0; chk_en = 1'b0; idle_run = 0;
        m_state = 0; m_idle = 0; m_wake_left = 0; last0 = '0; last1 = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // basic write/read, partial write, back-to-back reads
        do_req(1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
        do_req(1'b0, 14'h0010, 4'h0, 32'h0);
        idle(2);
        do_req(1'b1, 14'h0010, 4'b0101, 32'h11223344);
        do_req(1'b1, 14'h0011, 4'hF, 32'hCAFEF00D);
        do_req(1'b0, 14'h0010, 4'h0, 32'h0);
        do_req(1'b0, 14'h0011, 4'h0, 32'h0);
        check("partial_write", last0, 32'hDE22BE44);
        idle(2);
        check("partial_write_reg", bus1.rsp_dout, 32'hCAFEF00D);

        // automatic light sleep, then wake by request
        idle(12);
        do_req(1'b0, 14'h0010, 4'h0, 32'h0);
        idle(2);

        // deep sleep with a request pending, wake, data kept
        ds = 1'b1; v = 1'b1; we = 1'b0; addr = 14'h0011;
        repeat (5) tick();
        ds = 1'b0;
        do_req(1'b0, 14'h0011, 4'h0, 32'h0);
        idle(3);

        // shutdown during a wake from deep sleep
        ds = 1'b1; idle(3); ds = 1'b0; idle(2);
        sd = 1'b1; idle(3); sd = 1'b0; idle(20);
        do_req(1'b1, 14'h2000, 4'hF, $urandom);
        do_req(1'b0, 14'h2000, 4'h0, 32'h0);
        idle(3);

        // reset during WAKE, and reset with a read in flight
        ds = 1'b1; idle(2); ds = 1'b0; idle(2);
        rst = 1'b1; idle(1); rst = 1'b0; idle(2);
        do_req(1'b0, 14'h2000, 4'h0, 32'h0);
        rst = 1'b1; idle(1); rst = 1'b0; idle(3);

        // randomized traffic with power requests and occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!ds && $urandom_range(0, 99) == 0) ds = 1'b1;
            else if (ds && $urandom_range(0, 7) == 0) ds = 1'b0;
            if (!sd && $urandom_range(0, 149) == 0) sd = 1'b1;
            else if (sd && $urandom_range(0, 9) == 0) sd = 1'b0;
            if (idle_run == 0 && $urandom_range(0, 59) == 0) idle_run = $urandom_range(6, 14);
            r = $urandom_range(0, 9);
            if (rst || idle_run > 0 || r < 3) begin
                v = 1'b0;
                if (idle_run > 0) idle_run--;
            end else begin
                ra = pool[$urandom_range(0, 7)];
                v = 1'b1; addr = ra;
                if (r < 6 && m_mem.exists(int'(ra))) begin
                    we = 1'b0;
                end else begin
                    we = 1'b1;
                    wem = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                    din = $urandom;
                end
            end
            tick();
        end
        rst = 1'b0; ds = 1'b0; sd = 1'b0;
        idle(24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/e203_tcm_sram_pmu.md
Name: e203_tcm_sram_pmu

Overview:
- Parametrised TCM SRAM block for ITCM/DTCM, generalising the fixed single-macro wrapper.
- Holds a behavioural multi-bank SRAM array, a valid/ready request port, and an optional output register.
- A power-mode FSM covers active, light-sleep, deep-sleep and shutdown, with counted wake-up latency.
- Sits between the core's TCM controller and the memory; replaces direct sd/ds/ls pin driving with a request-level protocol.

Parameters:
- DW, 32, data width in bits; multiple of 8.
- AW, 14, word-address width; depth = 2**AW words.
- MW, DW/8, byte write-mask width.
- BANKS, 2, number of banks; power of 2, at least 1. The bank is selected by the top log2(BANKS) address bits.
- DOUT_REG, 0, 1 adds an output register stage to read latency.
- IDLE_LS, 8, idle ACT cycles before automatic light sleep; 0 disables automatic light sleep.
- WAKE_LS, 1, wake cycles from LS; minimum 1.
- WAKE_DS, 4, wake cycles from DS; minimum 1.
- WAKE_SD, 16, wake cycles from SD; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wem  in  MW  byte write enable; ignored for reads.
- req_din  in  DW  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse.
- rsp_dout  out  DW  read data; held until the next read response.
- bank_cs  out  BANKS  one-hot bank select, asserted in the accept cycle.
- pwr_ds_req  in  1  level request for deep sleep.
- pwr_sd_req  in  1  level request for shutdown; has priority over ds.
- pwr_state  out  3  0=ACT, 1=LS, 2=DS, 3=SD, 4=WAKE.

Behaviour:
- Reset:
  - pwr_state=ACT; idle and wake counters 0.
  - rsp_valid=0, rsp_dout=0, bank_cs=0.
  - Array contents are not reset.
- req_ready = (state==ACT), purely combinational from state. No request is accepted in any other state.
- Write accept: for every i with wem[i]=1, byte i of mem[addr] is updated at the accept clock edge. No response is generated.
- Read accept at cycle N:
  - rsp_valid and rsp_dout appear at N+1 when DOUT_REG=0, or at N+2 when DOUT_REG=1.
  - Back-to-back reads give one response per cycle.
  - A read directly after a write to the same address returns the new data.
- bank_cs[addr[AW-1 -: log2(BANKS)]] = 1 in the accept cycle only. With BANKS=1, bank_cs = accept.
- FSM transitions, evaluated each cycle in priority order:
  - ACT: pwr_sd_req -> SD; else pwr_ds_req -> DS; else if IDLE_LS!=0, the idle count reaches IDLE_LS and no read is in flight -> LS.
    - The idle count increments on cycles without req_valid, clears on req_valid, and saturates.
    - A read accepted in the same cycle as an sd/ds request still completes; the data path drains regardless of state.
  - LS: pwr_sd_req -> SD; else pwr_ds_req -> DS; else req_valid -> WAKE with counter=WAKE_LS. The request stays pending, with ready low.
  - DS: pwr_sd_req -> SD; else !pwr_ds_req -> WAKE with counter=WAKE_DS.
  - SD: !pwr_sd_req -> WAKE with counter=WAKE_SD, unless pwr_ds_req is high, in which case -> DS.
    - Array contents become undefined on SD entry.
  - WAKE: the counter decrements each cycle; ACT is entered the cycle after the counter reaches 1.
    - pwr_sd_req or pwr_ds_req asserted during WAKE -> SD or DS, and the wake is aborted.
- Idle count clears on every entry to ACT.
- rst asserted in any state, including WAKE or with a read in flight, forces the reset values on the next edge. Pending responses are dropped.
- Arithmetic: counters are sized to clog2(max(IDLE_LS, WAKE_SD)+1) bits. No wrap: the idle count saturates at IDLE_LS.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with wem=4'hF, then read 0x10 -> rsp_valid 1 cycle after accept (DOUT_REG=0), rsp_dout=0xDEADBEEF. With DOUT_REG=1 the response comes 2 cycles after accept.
- Partial write wem=4'b0101 with din 0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44. Back-to-back reads of 0x10 and 0x11 give two consecutive rsp_valid cycles.
- Idle 8 cycles in ACT -> pwr_state=1 on cycle 9. req_valid then gives ready=0, WAKE for 1 cycle, ACT, then accept.
- pwr_ds_req=1 -> DS, ready stays low. Deassert -> 4 WAKE cycles, then ACT, and data written before DS is preserved.
- pwr_sd_req=1 during WAKE from DS -> SD immediately. Deassert -> 16 WAKE cycles then ACT. BANKS=2, AW=14: addr 0x2000 gives bank_cs=2'b10.
- rst asserted while in WAKE with a read in flight -> next cycle pwr_state=0, rsp_valid=0, rsp_dout=0.
